// File: rtl/morse_rx_decoder.sv
// Morse line receiver: times marks and spaces on a synchronized keyed line,
// classifies dots/dashes and decodes A-Z letters with valid/error strobes.
module morse_rx_decoder #(
  parameter int unsigned UNIT_CYCLES   = 25000000,
  parameter int unsigned GLITCH_CYCLES = UNIT_CYCLES / 4,
  parameter int unsigned STUCK_UNITS   = 6
) (
  input  logic       CLOCK_50,
  input  logic       KEY0_N,
  input  logic       morse_in,
  input  logic       clear,
  output logic [4:0] letter,
  output logic       letter_valid,
  output logic       letter_err,
  output logic [2:0] sym_count,
  output logic       busy
);

  localparam int unsigned STUCK_CYCLES = STUCK_UNITS * UNIT_CYCLES;
  localparam int unsigned CNT_W        = $clog2(STUCK_CYCLES + 1);

  localparam logic [CNT_W-1:0] STUCK_LIM  = CNT_W'(STUCK_CYCLES);
  localparam logic [CNT_W-1:0] DASH_LIM   = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] GLITCH_LIM = CNT_W'(GLITCH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MARK,
    S_SPACE,
    S_STUCK
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q;
  logic             morse_s;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       pat_q, pat_d;
  logic [2:0]       len_q, len_d;
  logic             ovf_q, ovf_d;
  logic [4:0]       letter_q, letter_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             sym_dash;
  logic [5:0]       lookup;

  // Returns {hit, code}; the pattern is left-justified so the first symbol
  // sits in bit 3 regardless of letter length.
  function automatic logic [5:0] morse_lookup(input logic [2:0] len,
                                              input logic [3:0] pat);
    logic [3:0] just;
    logic [5:0] res;
    just = pat << (3'd4 - len);
    res  = 6'd0;
    case ({len, just})
      7'b010_0100: res = {1'b1, 5'd0};
      7'b100_1000: res = {1'b1, 5'd1};
      7'b100_1010: res = {1'b1, 5'd2};
      7'b011_1000: res = {1'b1, 5'd3};
      7'b001_0000: res = {1'b1, 5'd4};
      7'b100_0010: res = {1'b1, 5'd5};
      7'b011_1100: res = {1'b1, 5'd6};
      7'b100_0000: res = {1'b1, 5'd7};
      7'b010_0000: res = {1'b1, 5'd8};
      7'b100_0111: res = {1'b1, 5'd9};
      7'b011_1010: res = {1'b1, 5'd10};
      7'b100_0100: res = {1'b1, 5'd11};
      7'b010_1100: res = {1'b1, 5'd12};
      7'b010_1000: res = {1'b1, 5'd13};
      7'b011_1110: res = {1'b1, 5'd14};
      7'b100_0110: res = {1'b1, 5'd15};
      7'b100_1101: res = {1'b1, 5'd16};
      7'b011_0100: res = {1'b1, 5'd17};
      7'b011_0000: res = {1'b1, 5'd18};
      7'b001_1000: res = {1'b1, 5'd19};
      7'b011_0010: res = {1'b1, 5'd20};
      7'b100_0001: res = {1'b1, 5'd21};
      7'b011_0110: res = {1'b1, 5'd22};
      7'b100_1001: res = {1'b1, 5'd23};
      7'b100_1011: res = {1'b1, 5'd24};
      7'b100_1100: res = {1'b1, 5'd25};
      default:     res = 6'd0;
    endcase
    return res;
  endfunction

  // morse_in is asynchronous to CLOCK_50; all timing uses the second flop.
  always_ff @(posedge CLOCK_50 or negedge KEY0_N) begin
    if (!KEY0_N) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], morse_in};
  end

  assign morse_s  = sync_q[1];
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
  assign sym_dash = (cnt_q >= DASH_LIM);
  assign lookup   = morse_lookup(len_q, pat_q);

  // NOTE: every register here is a small flop, so all of them get the async
  // reset; non-blocking (<=) keeps each flop sampling pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge KEY0_N) begin
    if (!KEY0_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pat_q    <= 4'd0;
      len_q    <= 3'd0;
      ovf_q    <= 1'b0;
      letter_q <= 5'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // NOTE: every next-state value is defaulted first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    letter_d = letter_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (morse_s) begin
          state_d = S_MARK;
          cnt_d   = CNT_ONE;
        end
      end

      S_MARK: begin
        if (morse_s) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= STUCK_LIM) begin
            err_d   = 1'b1;
            pat_d   = 4'd0;
            len_d   = 3'd0;
            ovf_d   = 1'b0;
            state_d = S_STUCK;
          end
        end else if (cnt_q < GLITCH_LIM) begin
          if (len_q != 3'd0) begin
            state_d = S_SPACE;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          if (len_q == 3'd4) begin
            ovf_d = 1'b1;
          end else begin
            pat_d = {pat_q[2:0], sym_dash};
            len_d = len_q + 3'd1;
          end
          state_d = S_SPACE;
          cnt_d   = CNT_ONE;
        end
      end

      S_SPACE: begin
        if (morse_s) begin
          state_d = S_MARK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= DASH_LIM) begin
            if (lookup[5] && !ovf_q) begin
              letter_d = lookup[4:0];
              valid_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            pat_d   = 4'd0;
            len_d   = 3'd0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end

      S_STUCK: begin
        if (!morse_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Clear wins over finalize and stuck detection; the held letter survives.
    if (clear) begin
      pat_d    = 4'd0;
      len_d    = 3'd0;
      ovf_d    = 1'b0;
      cnt_d    = '0;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      letter_d = letter_q;
      state_d  = morse_s ? S_STUCK : S_IDLE;
    end
  end

  assign letter       = letter_q;
  assign letter_valid = valid_q;
  assign letter_err   = err_q;
  assign sym_count    = len_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Directed bench for morse_rx_decoder: a table of letters plus hand-written
// sequences for latency, glitch, stuck line, reset and clear.
module tb_morse_rx_decoder;

  localparam int UNIT = 10;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       morse_in = 1'b0;
  logic       clear    = 1'b0;
  logic [4:0] letter;
  logic       letter_valid;
  logic       letter_err;
  logic [2:0] sym_count;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int n_both   = 0;
  logic [4:0] valid_log[$];
  logic [4:0] exp_letter = 5'd0;

  typedef struct {
    string      name;
    string      code;
    bit         ok;
    logic [4:0] code_exp;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  morse_rx_decoder #(
    .UNIT_CYCLES  (UNIT),
    .GLITCH_CYCLES(2),
    .STUCK_UNITS  (6)
  ) dut (
    .CLOCK_50    (clk),
    .KEY0_N      (rst_n),
    .morse_in    (morse_in),
    .clear       (clear),
    .letter      (letter),
    .letter_valid(letter_valid),
    .letter_err  (letter_err),
    .sym_count   (sym_count),
    .busy        (busy)
  );

  always @(negedge clk) begin
    if (letter_valid) begin
      n_valid++;
      valid_log.push_back(letter);
    end
    if (letter_err) n_err++;
    if (letter_valid && letter_err) n_both++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    morse_in = v;
    repeat (n) @(negedge clk);
  endtask

  // Dot = 1 unit high, dash = 3 units high, 1-unit gap between symbols.
  task automatic send_code(input string code);
    byte c;
    for (int i = 0; i < code.len(); i++) begin
      c = code[i];
      if (i > 0) hold(1'b0, UNIT);
      hold(1'b1, (c == "-") ? 3 * UNIT : UNIT);
    end
    morse_in = 1'b0;
  endtask

  task automatic add_vec(input string n, input string c, input bit ok, input logic [4:0] l);
    vec_t v;
    v.name     = n;
    v.code     = c;
    v.ok       = ok;
    v.code_exp = l;
    vq.push_back(v);
  endtask

  task automatic expect_letter(input string name, input string code, input logic [4:0] l);
    int v0;
    int e0;
    v0 = n_valid;
    e0 = n_err;
    send_code(code);
    hold(1'b0, 3 * UNIT);
    exp_letter = l;
    check({name, "_valid"}, n_valid - v0, 1);
    check({name, "_err"}, n_err - e0, 0);
    check({name, "_letter"}, letter, exp_letter);
  endtask

  // Clear asserted for the single cycle whose edge is at_k edges after
  // morse_in falls; the natural finalize edge is 22 (2 sync + 20 cycles).
  task automatic clear_test(input string name, input int at_k);
    int v0;
    int e0;
    v0 = n_valid;
    e0 = n_err;
    send_code("-.-");
    for (int k = 1; k <= 40; k++) begin
      clear = (k == at_k);
      @(negedge clk);
    end
    clear = 1'b0;
    check({name, "_valid"}, n_valid - v0, 0);
    check({name, "_err"}, n_err - e0, 0);
    check({name, "_letter"}, letter, exp_letter);
    check({name, "_busy"}, busy, 0);
    check({name, "_sym"}, sym_count, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    int e0;
    int qs;
    int hit_k;
    int err_k;

    add_vec("B",     "-...",  1'b1, 5'd1);
    add_vec("A",     ".-",    1'b1, 5'd0);
    add_vec("E",     ".",     1'b1, 5'd4);
    add_vec("H",     "....",  1'b1, 5'd7);
    add_vec("dots5", ".....", 1'b0, 5'd0);
    add_vec("J",     ".---",  1'b1, 5'd9);
    add_vec("O",     "---",   1'b1, 5'd14);
    add_vec("bad4",  "..--",  1'b0, 5'd0);
    add_vec("Q",     "--.-",  1'b1, 5'd16);
    add_vec("S",     "...",   1'b1, 5'd18);
    add_vec("dash4", "----",  1'b0, 5'd0);
    add_vec("T",     "-",     1'b1, 5'd19);
    add_vec("Y",     "-.--",  1'b1, 5'd24);
    add_vec("Z",     "--..",  1'b1, 5'd25);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_letter", letter, 0);
    check("rst_valid", letter_valid, 0);
    check("rst_err", letter_err, 0);
    check("rst_sym", sym_count, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    hold(1'b0, 5);

    // A: exact finalize latency measured from the morse_in falling edge
    v0    = n_valid;
    hit_k = -1;
    hold(1'b1, UNIT);
    hold(1'b0, UNIT);
    hold(1'b1, 3 * UNIT);
    morse_in = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 21) begin
        check("a_sym_before", sym_count, 2);
        check("a_busy_before", busy, 1);
      end
      if (letter_valid && hit_k < 0) begin
        hit_k = k;
        check("a_letter", letter, 0);
        check("a_sym_at_valid", sym_count, 0);
        check("a_busy_at_valid", busy, 0);
      end
    end
    check("a_latency", hit_k, 22);
    check("a_count", n_valid - v0, 1);
    exp_letter = 5'd0;

    // Table-driven letters and invalid patterns
    for (int i = 0; i < vq.size(); i++) begin
      v0 = n_valid;
      e0 = n_err;
      send_code(vq[i].code);
      hold(1'b0, 3 * UNIT);
      if (vq[i].ok) exp_letter = vq[i].code_exp;
      check({vq[i].name, "_valid"}, n_valid - v0, vq[i].ok ? 1 : 0);
      check({vq[i].name, "_err"}, n_err - e0, vq[i].ok ? 0 : 1);
      check({vq[i].name, "_letter"}, letter, exp_letter);
      check({vq[i].name, "_sym"}, sym_count, 0);
      check({vq[i].name, "_busy"}, busy, 0);
    end

    // Z then E back-to-back with a 30-cycle gap
    v0 = n_valid;
    e0 = n_err;
    qs = valid_log.size();
    send_code("--..");
    hold(1'b0, 3 * UNIT);
    send_code(".");
    hold(1'b0, 3 * UNIT);
    check("ze_count", n_valid - v0, 2);
    check("ze_err", n_err - e0, 0);
    if (valid_log.size() >= qs + 2) begin
      check("ze_first", valid_log[qs], 25);
      check("ze_second", valid_log[qs + 1], 4);
    end else begin
      check("ze_log_size", valid_log.size(), qs + 2);
    end
    exp_letter = 5'd4;

    // 1-cycle high glitch inside E's trailing gap must not add a dot
    expect_letter("t_before_glitch", "-", 5'd19);
    v0 = n_valid;
    e0 = n_err;
    send_code(".");
    hold(1'b0, 5);
    hold(1'b1, 1);
    hold(1'b0, 40);
    exp_letter = 5'd4;
    check("glitch_valid", n_valid - v0, 1);
    check("glitch_err", n_err - e0, 0);
    check("glitch_letter", letter, exp_letter);

    // Stuck line: 70-cycle mark, error on mark cycle 60
    v0    = n_valid;
    e0    = n_err;
    err_k = -1;
    morse_in = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (letter_err && err_k < 0) err_k = k;
    end
    check("stuck_err_cycle", err_k, 62);
    check("stuck_busy", busy, 1);
    hold(1'b0, 3 * UNIT);
    check("stuck_err_count", n_err - e0, 1);
    check("stuck_valid", n_valid - v0, 0);
    check("stuck_idle", busy, 0);
    check("stuck_letter", letter, exp_letter);
    expect_letter("t_after_stuck", "-", 5'd19);

    // Reset mid-MARK discards the partial letter and clears the held letter
    send_code(".");
    hold(1'b0, UNIT);
    hold(1'b1, 15);
    check("pre_rst_sym", sym_count, 1);
    check("pre_rst_busy", busy, 1);
    rst_n    = 1'b0;
    morse_in = 1'b0;
    #1;
    exp_letter = 5'd0;
    check("midrst_letter", letter, exp_letter);
    check("midrst_sym", sym_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", letter_valid, 0);
    check("midrst_err", letter_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v0 = n_valid;
    e0 = n_err;
    hold(1'b0, 3 * UNIT);
    check("post_rst_quiet", (n_valid - v0) + (n_err - e0), 0);
    expect_letter("m_after_rst", "--", 5'd12);

    // Clear one cycle before finalize, then in the finalize cycle itself
    clear_test("clr_early", 21);
    expect_letter("m_after_clr", "--", 5'd12);
    clear_test("clr_same", 22);
    expect_letter("n_after_clr", "-.", 5'd13);

    check("no_dual_strobe", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
